// File: rtl/int_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encodings,
// register offsets, source-ID width and the rotating-priority start helper.
package int_arbiter_pkg;

  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    REG_PEND = 2'b00,
    REG_MASK = 2'b01,
    REG_STAT = 2'b10,
    REG_EOI  = 2'b11
  } reg_addr_e;

  // Index following idx, wrapping to 0 past the last source.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx,
                                               input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/int_arbiter_if.sv
// Device-bus register port plus CPU request/ack handshake of the arbiter.
// master: bus/CPU side, slave: the arbiter.
interface int_arbiter_if;

  logic [1:0]                      add;
  logic                            write_en;
  logic [31:0]                     data_in;
  logic [31:0]                     data_out;
  logic                            cpu_irq;
  logic                            cpu_ack;
  logic [int_arbiter_pkg::ID_W-1:0] irq_id;

  modport master (
    output add, write_en, data_in, cpu_ack,
    input  data_out, cpu_irq, irq_id
  );

  modport slave (
    input  add, write_en, data_in, cpu_ack,
    output data_out, cpu_irq, irq_id
  );

endinterface

// File: rtl/int_prio_sel.sv
// Combinational priority select: first set bit of vec_i searching upward
// from start_i with wrap-around. start_i = 0 gives plain lowest-index-wins.
module int_prio_sel
  import int_arbiter_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic [N_SRC-1:0] vec_i,
  input  logic [ID_W-1:0]  start_i,
  output logic             found_o,
  output logic [ID_W-1:0]  id_o
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk all sources in rotated order, keep the first hit.
  always_comb begin
    // NOTE: every output/temp gets a default before the loop so no path leaves it unassigned, which would infer a latch.
    found_o = 1'b0;
    id_o    = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum = {1'b0, start_i} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_SRC)) sum = sum - (ID_W+1)'(N_SRC);
      idx = sum[ID_W-1:0];
      if (!found_o && vec_i[idx]) begin
        found_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: latches rising edges of device request lines, masks
// them, grants one source to the CPU and runs the ack / EOI handshake.
// Build option: INT_ARB_ROUND_ROBIN_EN selects rotating priority (search
// starts after the last acknowledged source); default is fixed priority
// with source 0 highest.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_src,
  int_arbiter_if.slave     bus
);

  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] edge_w;
  state_e           state_q;
  logic [ID_W-1:0]  id_q;
  logic             cpu_irq_q;

  logic             wr_pend, wr_mask, wr_eoi;
  logic             ack_w, withdraw_w;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  start_id;

  assign wr_pend = bus.write_en && (bus.add == REG_PEND);
  assign wr_mask = bus.write_en && (bus.add == REG_MASK);
  assign wr_eoi  = bus.write_en && (bus.add == REG_EOI);
  assign edge_w  = irq_src & ~prev_q;
  assign ack_w   = (state_q == ST_REQ) && bus.cpu_ack;

`ifdef INT_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_q;
  assign start_id = wrap_inc(last_q, N_SRC);
`else
  assign start_id = '0;
`endif

  int_prio_sel #(.N_SRC(N_SRC)) u_prio_sel (
    .vec_i   (pending_q & mask_q),
    .start_i (start_id),
    .found_o (grant_found),
    .id_o    (grant_id)
  );

  // Next pending/mask: W1C and ack clears first, then new edges so set beats clear.
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    if (wr_pend) pending_d = pending_d & ~bus.data_in[N_SRC-1:0];
    if (wr_mask) mask_d = bus.data_in[N_SRC-1:0];
    if (ack_w) pending_d[id_q] = 1'b0;
    pending_d = pending_d | edge_w;
  end

  // A request is withdrawn as soon as its source is cleared or masked this cycle.
  assign withdraw_w = !(pending_d[id_q] && mask_d[id_q]);

  // Edge detector, pending and mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values regardless of statement order.
    if (!reset_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      prev_q    <= irq_src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Grant FSM with registered cpu_irq and frozen source ID.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      cpu_irq_q <= 1'b0;
`ifdef INT_ARB_ROUND_ROBIN_EN
      last_q    <= ID_W'(N_SRC - 1);
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            state_q   <= ST_REQ;
            id_q      <= grant_id;
            cpu_irq_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.cpu_ack) begin
            state_q   <= ST_SERVICE;
            cpu_irq_q <= 1'b0;
`ifdef INT_ARB_ROUND_ROBIN_EN
            last_q    <= id_q;
`endif
          end else if (withdraw_w) begin
            state_q   <= ST_IDLE;
            cpu_irq_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (wr_eoi) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          cpu_irq_q <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux, combinational from the address.
  always_comb begin
    case (bus.add)
      REG_PEND: bus.data_out = {{(32-N_SRC){1'b0}}, pending_q};
      REG_MASK: bus.data_out = {{(32-N_SRC){1'b0}}, mask_q};
      REG_STAT: bus.data_out = {22'd0, state_q, 5'd0, id_q};
      default:  bus.data_out = 32'd0;
    endcase
  end

  assign bus.cpu_irq = cpu_irq_q;
  assign bus.irq_id  = id_q;

  // Upper write-data bits carry no register state.
  logic unused_data;
  assign unused_data = ^bus.data_in[31:N_SRC];

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: edge capture, masking, grant latency,
// withdraw, set-beats-clear, EOI handling and rotating/fixed priority.
module tb_int_arbiter;
  import int_arbiter_pkg::*;

  localparam int N_SRC = 6;

  logic             clk;
  logic             reset_n;
  logic [N_SRC-1:0] irq_src;
  int               checks;
  int               failures;

  int_arbiter_if bus ();

  int_arbiter #(.N_SRC(N_SRC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    bus.add = a;
    #1;
    d = bus.data_out;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.add      = a;
    bus.data_in  = d;
    bus.write_en = 1'b1;
    step();
    bus.write_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    irq_src      = '0;
    bus.add      = 2'b00;
    bus.write_en = 1'b0;
    bus.data_in  = 32'd0;
    bus.cpu_ack  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL reset_cpu_irq actual=%b required=0", bus.cpu_irq); end
    checks++; if (bus.irq_id !== 3'd0) begin failures++; $display("FAIL reset_irq_id actual=%0d required=0", bus.irq_id); end
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_pend actual=%h required=0", rd); end
    rd_reg(REG_MASK, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_mask actual=%h required=0", rd); end
    rd_reg(REG_STAT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_stat actual=%h required=0", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    do_reset();
    bus_write(REG_MASK, 32'h3F);
    irq_src = 6'b000100;
    step();
    irq_src = '0;
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h04) begin failures++; $display("FAIL basic_pend_t1 actual=%h required=04", rd); end
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL basic_irq_t1 actual=%b required=0", bus.cpu_irq); end
    step();
    checks++; if (bus.cpu_irq !== 1'b1) begin failures++; $display("FAIL basic_irq_t2 actual=%b required=1", bus.cpu_irq); end
    checks++; if (bus.irq_id !== 3'd2) begin failures++; $display("FAIL basic_id_t2 actual=%0d required=2", bus.irq_id); end
    rd_reg(REG_STAT, rd);
    checks++; if (rd !== 32'h102) begin failures++; $display("FAIL basic_stat_req actual=%h required=102", rd); end
    bus.cpu_ack = 1'b1;
    step();
    bus.cpu_ack = 1'b0;
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL basic_pend_ack actual=%h required=0", rd); end
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL basic_irq_ack actual=%b required=0", bus.cpu_irq); end
    rd_reg(REG_STAT, rd);
    checks++; if (rd !== 32'h202) begin failures++; $display("FAIL basic_stat_svc actual=%h required=202", rd); end
    bus_write(REG_EOI, 32'h0);
    rd_reg(REG_STAT, rd);
    checks++; if (rd[9:8] !== 2'b00) begin failures++; $display("FAIL basic_state_eoi actual=%b required=00", rd[9:8]); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] rd;
    do_reset();
    bus_write(REG_MASK, 32'h3F);
    irq_src = 6'b010010;
    step();
    irq_src = '0;
    step();
    checks++; if (bus.irq_id !== 3'd1) begin failures++; $display("FAIL same_first_id actual=%0d required=1", bus.irq_id); end
    bus.cpu_ack = 1'b1;
    step();
    bus.cpu_ack = 1'b0;
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL same_pend_ack actual=%h required=10", rd); end
    step();
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL same_no_grant_svc actual=%b required=0", bus.cpu_irq); end
    bus_write(REG_EOI, 32'h0);
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL same_irq_eoi1 actual=%b required=0", bus.cpu_irq); end
    step();
    checks++; if (bus.cpu_irq !== 1'b1) begin failures++; $display("FAIL same_irq_eoi2 actual=%b required=1", bus.cpu_irq); end
    checks++; if (bus.irq_id !== 3'd4) begin failures++; $display("FAIL same_second_id actual=%0d required=4", bus.irq_id); end
  endtask

  task automatic test_mask();
    logic [31:0] rd;
    do_reset();
    irq_src = 6'b001000;
    step();
    irq_src = '0;
    step();
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL mask_pend actual=%h required=08", rd); end
    step();
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL mask_irq_masked actual=%b required=0", bus.cpu_irq); end
    bus_write(REG_MASK, 32'h08);
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL mask_irq_wr actual=%b required=0", bus.cpu_irq); end
    step();
    checks++; if (bus.cpu_irq !== 1'b1) begin failures++; $display("FAIL mask_irq_en actual=%b required=1", bus.cpu_irq); end
    checks++; if (bus.irq_id !== 3'd3) begin failures++; $display("FAIL mask_id actual=%0d required=3", bus.irq_id); end
  endtask

  task automatic test_withdraw();
    logic [31:0] rd;
    do_reset();
    bus_write(REG_MASK, 32'h3F);
    irq_src = 6'b000001;
    step();
    irq_src = '0;
    step();
    checks++; if (bus.cpu_irq !== 1'b1 || bus.irq_id !== 3'd0) begin failures++; $display("FAIL wd_req actual=%b/%0d required=1/0", bus.cpu_irq, bus.irq_id); end
    bus_write(REG_MASK, 32'h0);
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL wd_mask_irq actual=%b required=0", bus.cpu_irq); end
    rd_reg(REG_STAT, rd);
    checks++; if (rd[9:8] !== 2'b00) begin failures++; $display("FAIL wd_mask_state actual=%b required=00", rd[9:8]); end
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h01) begin failures++; $display("FAIL wd_mask_pend actual=%h required=01", rd); end
    bus_write(REG_MASK, 32'h3F);
    step();
    checks++; if (bus.cpu_irq !== 1'b1 || bus.irq_id !== 3'd0) begin failures++; $display("FAIL wd_rereq actual=%b/%0d required=1/0", bus.cpu_irq, bus.irq_id); end
    bus_write(REG_PEND, 32'h01);
    checks++; if (bus.cpu_irq !== 1'b0) begin failures++; $display("FAIL wd_w1c_irq actual=%b required=0", bus.cpu_irq); end
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wd_w1c_pend actual=%h required=0", rd); end
    irq_src = 6'b000001;
    step();
    irq_src = '0;
    step();
    bus.cpu_ack = 1'b1;
    bus_write(REG_MASK, 32'h0);
    bus.cpu_ack = 1'b0;
    rd_reg(REG_STAT, rd);
    checks++; if (rd[9:8] !== 2'b10) begin failures++; $display("FAIL wd_ack_wins actual=%b required=10", rd[9:8]); end
    bus_write(REG_MASK, 32'h3F);
    bus_write(REG_EOI, 32'h0);
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] rd;
    do_reset();
    irq_src = 6'b100000;
    step();
    irq_src = '0;
    step();
    irq_src = 6'b100000;
    bus_write(REG_PEND, 32'h20);
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h20) begin failures++; $display("FAIL sbc_pend actual=%h required=20", rd); end
    bus_write(REG_PEND, 32'h20);
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sbc_level_w1c actual=%h required=0", rd); end
    irq_src = '0;
    bus_write(REG_EOI, 32'h0);
    rd_reg(REG_STAT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL eoi_idle_stat actual=%h required=0", rd); end
    bus_write(REG_MASK, 32'h20);
    irq_src = 6'b100000;
    step();
    irq_src = '0;
    step();
    bus_write(REG_EOI, 32'h0);
    rd_reg(REG_STAT, rd);
    checks++; if (rd !== 32'h105) begin failures++; $display("FAIL eoi_req_stat actual=%h required=105", rd); end
    checks++; if (bus.cpu_irq !== 1'b1) begin failures++; $display("FAIL eoi_req_irq actual=%b required=1", bus.cpu_irq); end
  endtask

  task automatic test_round_robin();
    logic [31:0]     rd;
    logic [ID_W-1:0] exp_id;
    do_reset();
    bus_write(REG_MASK, 32'h03);
    irq_src = 6'b000011;
    step();
    irq_src = '0;
    step();
    for (int k = 0; k < 4; k++) begin
`ifdef INT_ARB_ROUND_ROBIN_EN
      exp_id = ID_W'(k % 2);
`else
      exp_id = '0;
`endif
      checks++; if (bus.cpu_irq !== 1'b1 || bus.irq_id !== exp_id) begin failures++; $display("FAIL rr_grant%0d actual=%b/%0d required=1/%0d", k, bus.cpu_irq, bus.irq_id, exp_id); end
      bus.cpu_ack = 1'b1;
      step();
      bus.cpu_ack = 1'b0;
      irq_src = 6'b000011;
      step();
      irq_src = '0;
      step();
      bus_write(REG_EOI, 32'h0);
      step();
    end
    bus.cpu_ack = 1'b1;
    step();
    bus.cpu_ack = 1'b0;
    rd_reg(REG_STAT, rd);
    checks++; if (rd[9:8] !== 2'b10) begin failures++; $display("FAIL rr_in_service actual=%b required=10", rd[9:8]); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.cpu_irq !== 1'b0 || bus.irq_id !== 3'd0) begin failures++; $display("FAIL async_rst_out actual=%b/%0d required=0/0", bus.cpu_irq, bus.irq_id); end
    rd_reg(REG_PEND, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL async_rst_pend actual=%h required=0", rd); end
    rd_reg(REG_MASK, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL async_rst_mask actual=%h required=0", rd); end
    rd_reg(REG_STAT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL async_rst_stat actual=%h required=0", rd); end
    do_reset();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_same_cycle();
    test_mask();
    test_withdraw();
    test_set_beats_clear();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
